aes_encrypt_iterative: RTL and testbench

AES_ENCRYPT_ITERATIVE -- requirements
Module: aes_encrypt_iterative

---
 rtl/aes_encrypt_iterative.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_encrypt_iterative.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iterative.sv
// rtl/aes_encrypt_iterative.sv - AES-128 encryption, one round per clock, on-the-fly key expansion
// Helper blocks (S-box, round transforms, key step) precede the top module.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry a sits at bits [2047-8a -: 8], i.e. index {~a, 3'b111}.
   assign y = SBOX_TABLE[{~a, 3'b111} -: 8];
endmodule

module sub_bytes (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   for (genvar i = 0; i < 16; i++) begin : g_byte
      aes_sbox u_sbox (
         .a (state_in[8*i +: 8]),
         .y (state_out[8*i +: 8])
      );
   end
endmodule

module shift_rows (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   // Byte n = row (n%4), column (n/4); byte 0 lives in bits [127:120].
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign state_out[127 - 8*(r + 4*c) -: 8] =
            state_in[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
   end
endmodule

module mix_columns (
   input  logic [127:0] state_in,
   output logic [127:0] state_out
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = state_in[127 - 32*c -: 8];
      assign a1 = state_in[119 - 32*c -: 8];
      assign a2 = state_in[111 - 32*c -: 8];
      assign a3 = state_in[103 - 32*c -: 8];
      assign state_out[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign state_out[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign state_out[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign state_out[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end
endmodule

module add_round_key (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   output logic [127:0] state_out
);
   assign state_out = state_in ^ round_key;
endmodule

module key_expand (
   input  logic [127:0] rk_in,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_out
);
   logic [31:0] w0, w1, w2, w3, rot_w3, sub_w3, temp;
   logic [31:0] n0, n1, n2, n3;

   assign w0 = rk_in[127:96];
   assign w1 = rk_in[95:64];
   assign w2 = rk_in[63:32];
   assign w3 = rk_in[31:0];
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .a (rot_w3[8*i +: 8]),
         .y (sub_w3[8*i +: 8])
      );
   end

   assign temp = sub_w3 ^ {rcon, 24'h000000};
   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign rk_out = {n0, n1, n2, n3};
endmodule

module aes_encrypt_iterative (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plain_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] cipher_out,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_reg_q, state_reg_d;
   logic [127:0] rk_reg_q, rk_reg_d;
   logic [127:0] cipher_q, cipher_d;
   logic [3:0]   round_cnt_q, round_cnt_d;

   logic [7:0]   rcon;
   logic         last_round;
   logic [127:0] init_state, rk_next;
   logic [127:0] sb_out, sr_out, mc_out, mix_sel, round_out;

   assign last_round = (round_cnt_q == 4'd10);

   always_comb begin
      rcon = 8'h00;
      case (round_cnt_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   add_round_key u_ark_init (
      .state_in  (plain_in),
      .round_key (key_in),
      .state_out (init_state)
   );

   key_expand u_key_expand (
      .rk_in  (rk_reg_q),
      .rcon   (rcon),
      .rk_out (rk_next)
   );

   sub_bytes u_sub_bytes (
      .state_in  (state_reg_q),
      .state_out (sb_out)
   );

   shift_rows u_shift_rows (
      .state_in  (sb_out),
      .state_out (sr_out)
   );

   mix_columns u_mix_columns (
      .state_in  (sr_out),
      .state_out (mc_out)
   );

   // The final round skips MixColumns.
   assign mix_sel = last_round ? sr_out : mc_out;

   add_round_key u_ark_round (
      .state_in  (mix_sel),
      .round_key (rk_next),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d       = fsm_q;
      state_reg_d = state_reg_q;
      rk_reg_d    = rk_reg_q;
      cipher_d    = cipher_q;
      round_cnt_d = round_cnt_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_reg_d = init_state;
               rk_reg_d    = key_in;
               round_cnt_d = 4'd1;
               fsm_d       = ROUND;
            end
         end
         ROUND: begin
            state_reg_d = round_out;
            rk_reg_d    = rk_next;
            if (last_round) begin
               cipher_d = round_out;
               fsm_d    = DONE;
            end else begin
               round_cnt_d = round_cnt_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_reg_q <= '0;
         rk_reg_q    <= '0;
         cipher_q    <= '0;
         round_cnt_q <= '0;
      end else begin
         fsm_q       <= fsm_d;
         state_reg_q <= state_reg_d;
         rk_reg_q    <= rk_reg_d;
         cipher_q    <= cipher_d;
         round_cnt_q <= round_cnt_d;
      end
   end

   // Reset already parks the FSM in IDLE, so ready is masked while reset is held.
   assign in_ready   = (fsm_q == IDLE) && !rst;
   assign out_valid  = (fsm_q == DONE);
   assign busy       = (fsm_q == ROUND);
   assign cipher_out = cipher_q;
endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// tb/tb_aes_encrypt_iterative.sv - directed and randomized bench for aes_encrypt_iterative
// Reference AES is built from GF(2^8) arithmetic with byte arrays.

module tb_aes_encrypt_iterative;
   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plain_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] cipher_out;
   logic         busy;

   int tests;
   int fails;
   int cyc;
   logic [7:0] sbox_t [256];

   aes_encrypt_iterative dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plain_in   (plain_in),
      .key_in     (key_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cipher_out (cipher_out),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      logic [15:0] d;
      d = {x, x};
      return d[15-k -: 8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] rk [16];
      logic [7:0] tmp [4];
      logic [7:0] rc;
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         s[i]  = pt[127-8*i -: 8] ^ rk[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         tmp[0] = sbox_t[rk[13]] ^ rc;
         tmp[1] = sbox_t[rk[14]];
         tmp[2] = sbox_t[rk[15]];
         tmp[3] = sbox_t[rk[12]];
         for (int j = 0; j < 4; j++) rk[j] = rk[j] ^ tmp[j];
         for (int j = 4; j < 16; j++) rk[j] = rk[j] ^ rk[j-4];
         rc = gmul(rc, 8'h02);
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               t[row + 4*col] = sbox_t[s[row + 4*((col + row) % 4)]];
         for (int col = 0; col < 4; col++) begin
            a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
            if (r < 10) begin
               s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic accept(input logic [127:0] k, input logic [127:0] p);
      key_in   = k;
      plain_in = p;
      in_valid = 1'b1;
      check("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", {125'd0, busy, in_ready, out_valid}, 128'd4);
   endtask

   task automatic wait_done(input bit churn, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (churn) begin
            key_in   = rand128();
            plain_in = rand128();
            in_valid = 1'($urandom);
         end
         if (out_valid) break;
      end
      if (churn) in_valid = 1'b0;
   endtask

   initial begin
      logic [127:0] k, p, exp_c, held;
      int lat, acc, prev, guard;
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      key_in    = '0;
      plain_in  = '0;
      build_sbox();

      @(negedge clk);
      @(negedge clk);
      check("reset_cipher", cipher_out, 128'd0);
      check("reset_flags", {125'd0, in_ready, out_valid, busy}, 128'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", {127'd0, in_ready}, 128'd1);
      @(negedge clk);

      // FIPS-197 Appendix B
      accept(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
      wait_done(1'b0, lat);
      check("appb_latency", 128'(lat), 128'd10);
      check("appb_cipher", cipher_out, 128'h3925841d02dc09fbdc118597196a0b32);
      @(negedge clk);
      check("appb_idle_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
      check("appb_cipher_retained", cipher_out, 128'h3925841d02dc09fbdc118597196a0b32);

      // FIPS-197 Appendix C.1
      accept(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
      wait_done(1'b0, lat);
      check("appc1_latency", 128'(lat), 128'd10);
      check("appc1_cipher", cipher_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      @(negedge clk);

      // Inputs churn after acceptance
      k = rand128();
      p = rand128();
      accept(k, p);
      wait_done(1'b1, lat);
      check("churn_latency", 128'(lat), 128'd10);
      check("churn_cipher", cipher_out, aes_model(k, p));
      @(negedge clk);

      // Output backpressure for 20 cycles
      k = rand128();
      p = rand128();
      exp_c = aes_model(k, p);
      out_ready = 1'b0;
      accept(k, p);
      wait_done(1'b0, lat);
      check("bp_cipher", cipher_out, exp_c);
      held = cipher_out;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         key_in   = rand128();
         plain_in = rand128();
         check("bp_hold_flags", {126'd0, out_valid, in_ready}, 128'd2);
         check("bp_hold_cipher", cipher_out, held);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_flags", {126'd0, in_ready, out_valid}, 128'd2);
      check("bp_release_cipher", cipher_out, exp_c);

      // Reset while round 5 is pending
      accept(rand128(), rand128());
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midreset_cipher", cipher_out, 128'd0);
      check("midreset_flags", {125'd0, in_ready, out_valid, busy}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset_release_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
      @(negedge clk);
      accept(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
      wait_done(1'b0, lat);
      check("post_reset_latency", 128'(lat), 128'd10);
      check("post_reset_cipher", cipher_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      @(negedge clk);

      // Back-to-back random traffic
      prev = 0;
      for (int v = 0; v < 100; v++) begin
         k = rand128();
         p = rand128();
         key_in   = k;
         plain_in = p;
         in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
         end
         check("b2b_ready", {127'd0, in_ready}, 128'd1);
         acc = cyc;
         if (v > 0) check("b2b_spacing", 128'(acc - prev), 128'd12);
         prev = acc;
         @(negedge clk);
         wait_done(1'b0, lat);
         check("b2b_cipher", cipher_out, aes_model(k, p));
         @(negedge clk);
      end
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
